// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: two-requester AXI read-path arbiter.
// Shares one downstream read port between masters m0 and m1. AR requests are
// granted round-robin through a two-state IDLE/ISSUE FSM. The grant bit is
// prepended to the downstream AR ID, and R beats are routed back
// combinationally using that bit. A per-master outstanding-burst counter stops
// one requester from flooding the slave. Write channels are tied off.
// Optional feature: define AXI_RD_ARB_QOS_EN to let the strictly higher ar_qos
// win when both masters are eligible. Equal QoS falls back to the
// round-robin pointer.
module axi_read_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned S_ID_WIDTH      = 5,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned AR_USER_WIDTH   = 1,
  parameter int unsigned R_USER_WIDTH    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  // m0 read address channel
  input  logic                     m0_ar_valid,
  output logic                     m0_ar_ready,
  input  logic [ID_WIDTH-1:0]      m0_ar_id,
  input  logic [ADDR_WIDTH-1:0]    m0_ar_addr,
  input  logic [7:0]               m0_ar_len,
  input  logic [2:0]               m0_ar_size,
  input  logic [1:0]               m0_ar_burst,
  input  logic                     m0_ar_lock,
  input  logic [3:0]               m0_ar_cache,
  input  logic [2:0]               m0_ar_prot,
  input  logic [3:0]               m0_ar_qos,
  input  logic [3:0]               m0_ar_region,
  input  logic [AR_USER_WIDTH-1:0] m0_ar_user,
  // m0 read data channel
  output logic                     m0_r_valid,
  input  logic                     m0_r_ready,
  output logic [ID_WIDTH-1:0]      m0_r_id,
  output logic [DATA_WIDTH-1:0]    m0_r_data,
  output logic [1:0]               m0_r_resp,
  output logic                     m0_r_last,
  output logic [R_USER_WIDTH-1:0]  m0_r_user,
  // m0 write channels (tied off)
  output logic                     m0_aw_ready,
  output logic                     m0_w_ready,
  output logic                     m0_b_valid,
  output logic [ID_WIDTH-1:0]      m0_b_id,
  output logic [1:0]               m0_b_resp,
  // m1 read address channel
  input  logic                     m1_ar_valid,
  output logic                     m1_ar_ready,
  input  logic [ID_WIDTH-1:0]      m1_ar_id,
  input  logic [ADDR_WIDTH-1:0]    m1_ar_addr,
  input  logic [7:0]               m1_ar_len,
  input  logic [2:0]               m1_ar_size,
  input  logic [1:0]               m1_ar_burst,
  input  logic                     m1_ar_lock,
  input  logic [3:0]               m1_ar_cache,
  input  logic [2:0]               m1_ar_prot,
  input  logic [3:0]               m1_ar_qos,
  input  logic [3:0]               m1_ar_region,
  input  logic [AR_USER_WIDTH-1:0] m1_ar_user,
  // m1 read data channel
  output logic                     m1_r_valid,
  input  logic                     m1_r_ready,
  output logic [ID_WIDTH-1:0]      m1_r_id,
  output logic [DATA_WIDTH-1:0]    m1_r_data,
  output logic [1:0]               m1_r_resp,
  output logic                     m1_r_last,
  output logic [R_USER_WIDTH-1:0]  m1_r_user,
  // m1 write channels (tied off)
  output logic                     m1_aw_ready,
  output logic                     m1_w_ready,
  output logic                     m1_b_valid,
  output logic [ID_WIDTH-1:0]      m1_b_id,
  output logic [1:0]               m1_b_resp,
  // shared downstream read address channel
  output logic                     s_ar_valid,
  input  logic                     s_ar_ready,
  output logic [S_ID_WIDTH-1:0]    s_ar_id,
  output logic [ADDR_WIDTH-1:0]    s_ar_addr,
  output logic [7:0]               s_ar_len,
  output logic [2:0]               s_ar_size,
  output logic [1:0]               s_ar_burst,
  output logic                     s_ar_lock,
  output logic [3:0]               s_ar_cache,
  output logic [2:0]               s_ar_prot,
  output logic [3:0]               s_ar_qos,
  output logic [3:0]               s_ar_region,
  output logic [AR_USER_WIDTH-1:0] s_ar_user,
  // shared downstream read data channel
  input  logic                     s_r_valid,
  output logic                     s_r_ready,
  input  logic [S_ID_WIDTH-1:0]    s_r_id,
  input  logic [DATA_WIDTH-1:0]    s_r_data,
  input  logic [1:0]               s_r_resp,
  input  logic                     s_r_last,
  input  logic [R_USER_WIDTH-1:0]  s_r_user,
  // shared downstream write channels (tied off)
  output logic                     s_aw_valid,
  output logic [S_ID_WIDTH-1:0]    s_aw_id,
  output logic [ADDR_WIDTH-1:0]    s_aw_addr,
  output logic [7:0]               s_aw_len,
  output logic [2:0]               s_aw_size,
  output logic [1:0]               s_aw_burst,
  output logic                     s_w_valid,
  output logic [DATA_WIDTH-1:0]    s_w_data,
  output logic [DATA_WIDTH/8-1:0]  s_w_strb,
  output logic                     s_w_last,
  output logic                     s_b_ready
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  // The downstream ID must carry exactly one extra routing bit.
  if (S_ID_WIDTH != ID_WIDTH + 1) begin : g_bad_id_width
    $fatal(1, "axi_read_arbiter: S_ID_WIDTH must equal ID_WIDTH+1");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 255) begin : g_bad_max_outstanding
    $fatal(1, "axi_read_arbiter: MAX_OUTSTANDING must be in 1..255");
  end

  typedef enum logic {IDLE, ISSUE} state_e;

  // AR payload without valid/id, so the grant mux is a single assignment.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
    logic                     lock;
    logic [3:0]               cache;
    logic [2:0]               prot;
    logic [3:0]               qos;
    logic [3:0]               region;
    logic [AR_USER_WIDTH-1:0] user;
  } ar_pl_t;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                ptr_q, ptr_d;
  logic [1:0][CW-1:0]  cnt_q, cnt_d;

  logic [1:0] elig;
  logic       pick;
  logic       ar_hs;
  logic       r_sel;
  logic       r_last_hs;
  logic [1:0] inc;
  logic [1:0] dec;
  ar_pl_t     m0_pl, m1_pl, s_pl;

  assign m0_pl = '{addr: m0_ar_addr, len: m0_ar_len, size: m0_ar_size,
                   burst: m0_ar_burst, lock: m0_ar_lock, cache: m0_ar_cache,
                   prot: m0_ar_prot, qos: m0_ar_qos, region: m0_ar_region,
                   user: m0_ar_user};
  assign m1_pl = '{addr: m1_ar_addr, len: m1_ar_len, size: m1_ar_size,
                   burst: m1_ar_burst, lock: m1_ar_lock, cache: m1_ar_cache,
                   prot: m1_ar_prot, qos: m1_ar_qos, region: m1_ar_region,
                   user: m1_ar_user};

  assign elig[0] = m0_ar_valid && (cnt_q[0] < MAX_CNT);
  assign elig[1] = m1_ar_valid && (cnt_q[1] < MAX_CNT);

  // Choose the winner for the next IDLE grant: a lone eligible master wins,
  // otherwise QoS (when enabled) and then the round-robin pointer decide.
  always_comb begin
    pick = elig[1] && !elig[0];
    if (&elig) begin
`ifdef AXI_RD_ARB_QOS_EN
      if (m1_ar_qos > m0_ar_qos) begin
        pick = 1'b1;
      end else if (m0_ar_qos > m1_ar_qos) begin
        pick = 1'b0;
      end else begin
        pick = ptr_q;
      end
`else
      pick = ptr_q;
`endif
    end
  end

  // Drive the downstream AR channel from the granted master while in ISSUE.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    s_ar_valid  = 1'b0;
    s_ar_id     = '0;
    s_pl        = '0;
    m0_ar_ready = 1'b0;
    m1_ar_ready = 1'b0;
    if (state_q == ISSUE) begin
      if (grant_q) begin
        s_ar_valid  = m1_ar_valid;
        s_ar_id     = {1'b1, m1_ar_id};
        s_pl        = m1_pl;
        m1_ar_ready = s_ar_ready;
      end else begin
        s_ar_valid  = m0_ar_valid;
        s_ar_id     = {1'b0, m0_ar_id};
        s_pl        = m0_pl;
        m0_ar_ready = s_ar_ready;
      end
    end
  end

  assign s_ar_addr   = s_pl.addr;
  assign s_ar_len    = s_pl.len;
  assign s_ar_size   = s_pl.size;
  assign s_ar_burst  = s_pl.burst;
  assign s_ar_lock   = s_pl.lock;
  assign s_ar_cache  = s_pl.cache;
  assign s_ar_prot   = s_pl.prot;
  assign s_ar_qos    = s_pl.qos;
  assign s_ar_region = s_pl.region;
  assign s_ar_user   = s_pl.user;

  assign ar_hs = s_ar_valid && s_ar_ready;

  // Route each R beat to the master named by the prepended ID bit.
  always_comb begin
    r_sel      = s_r_id[S_ID_WIDTH-1];
    s_r_ready  = r_sel ? m1_r_ready : m0_r_ready;
    m0_r_valid = s_r_valid && !r_sel;
    m1_r_valid = s_r_valid && r_sel;
    m0_r_id    = '0;
    m0_r_data  = '0;
    m0_r_resp  = '0;
    m0_r_last  = 1'b0;
    m0_r_user  = '0;
    m1_r_id    = '0;
    m1_r_data  = '0;
    m1_r_resp  = '0;
    m1_r_last  = 1'b0;
    m1_r_user  = '0;
    if (r_sel) begin
      m1_r_id   = s_r_id[ID_WIDTH-1:0];
      m1_r_data = s_r_data;
      m1_r_resp = s_r_resp;
      m1_r_last = s_r_last;
      m1_r_user = s_r_user;
    end else begin
      m0_r_id   = s_r_id[ID_WIDTH-1:0];
      m0_r_data = s_r_data;
      m0_r_resp = s_r_resp;
      m0_r_last = s_r_last;
      m0_r_user = s_r_user;
    end
  end

  assign r_last_hs = s_r_valid && s_r_ready && s_r_last;

  // Next FSM state, grant, pointer and increment requests.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    inc     = 2'b00;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          grant_d = pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ar_hs) begin
          inc[grant_q] = 1'b1;
          ptr_d        = ~grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outstanding counters: +1 on AR accept, -1 on the last R beat. A last beat
  // at zero is a slave protocol error and is ignored so the count cannot wrap.
  always_comb begin
    dec = 2'b00;
    dec[r_sel] = r_last_hs && (cnt_q[r_sel] != '0);
    for (int i = 0; i < 2; i++) begin
      case ({inc[i], dec[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // FSM and counter registers; reset drops all in-flight bookkeeping at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write channels are not arbitrated: never accept, never respond.
  assign m0_aw_ready = 1'b0;
  assign m0_w_ready  = 1'b0;
  assign m0_b_valid  = 1'b0;
  assign m0_b_id     = '0;
  assign m0_b_resp   = '0;
  assign m1_aw_ready = 1'b0;
  assign m1_w_ready  = 1'b0;
  assign m1_b_valid  = 1'b0;
  assign m1_b_id     = '0;
  assign m1_b_resp   = '0;
  assign s_aw_valid  = 1'b0;
  assign s_aw_id     = '0;
  assign s_aw_addr   = '0;
  assign s_aw_len    = '0;
  assign s_aw_size   = '0;
  assign s_aw_burst  = '0;
  assign s_w_valid   = 1'b0;
  assign s_w_data    = '0;
  assign s_w_strb    = '0;
  assign s_w_last    = 1'b0;
  assign s_b_ready   = 1'b1;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Testbench for axi_read_arbiter (MAX_OUTSTANDING = 2, N = 4).
// Directed stimulus pushes expected AR and R transfers into queues; a
// negedge monitor pops and compares whenever a handshake is presented.
module tb_axi_read_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_ar_valid = 0, m1_ar_valid = 0;
  logic        m0_ar_ready, m1_ar_ready;
  logic [3:0]  m0_ar_id = 0, m1_ar_id = 0;
  logic [31:0] m0_ar_addr = 0, m1_ar_addr = 0;
  logic [3:0]  m0_ar_qos = 0, m1_ar_qos = 0;
  logic        m0_r_valid, m1_r_valid;
  logic        m0_r_ready = 1, m1_r_ready = 1;
  logic [3:0]  m0_r_id, m1_r_id;
  logic [63:0] m0_r_data, m1_r_data;
  logic [1:0]  m0_r_resp, m1_r_resp;
  logic        m0_r_last, m1_r_last;
  logic        m0_r_user, m1_r_user;
  logic        m0_aw_ready, m0_w_ready, m0_b_valid, m1_aw_ready, m1_w_ready, m1_b_valid;
  logic [3:0]  m0_b_id, m1_b_id;
  logic [1:0]  m0_b_resp, m1_b_resp;

  logic        s_ar_valid, s_ar_ready = 1;
  logic [4:0]  s_ar_id;
  logic [31:0] s_ar_addr;
  logic [7:0]  s_ar_len;
  logic [2:0]  s_ar_size, s_ar_prot;
  logic [1:0]  s_ar_burst;
  logic        s_ar_lock, s_ar_user;
  logic [3:0]  s_ar_cache, s_ar_qos, s_ar_region;
  logic        s_r_valid = 0, s_r_ready, s_r_last = 0;
  logic [4:0]  s_r_id = 0;
  logic [63:0] s_r_data = 0;
  logic        s_aw_valid, s_w_valid, s_w_last, s_b_ready;
  logic [4:0]  s_aw_id;
  logic [31:0] s_aw_addr;
  logic [7:0]  s_aw_len, s_w_strb;
  logic [2:0]  s_aw_size;
  logic [1:0]  s_aw_burst;
  logic [63:0] s_w_data;

  axi_read_arbiter #(.MAX_OUTSTANDING(2), .ID_WIDTH(4), .S_ID_WIDTH(5),
                     .ADDR_WIDTH(32), .DATA_WIDTH(64),
                     .AR_USER_WIDTH(1), .R_USER_WIDTH(1)) dut (
    .clk(clk), .rst(rst),
    .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready), .m0_ar_id(m0_ar_id),
    .m0_ar_addr(m0_ar_addr), .m0_ar_len(8'd0), .m0_ar_size(3'd3), .m0_ar_burst(2'd1),
    .m0_ar_lock(1'b0), .m0_ar_cache(4'd0), .m0_ar_prot(3'd0), .m0_ar_qos(m0_ar_qos),
    .m0_ar_region(4'd0), .m0_ar_user(1'b0),
    .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready), .m0_r_id(m0_r_id),
    .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp), .m0_r_last(m0_r_last), .m0_r_user(m0_r_user),
    .m0_aw_ready(m0_aw_ready), .m0_w_ready(m0_w_ready), .m0_b_valid(m0_b_valid),
    .m0_b_id(m0_b_id), .m0_b_resp(m0_b_resp),
    .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready), .m1_ar_id(m1_ar_id),
    .m1_ar_addr(m1_ar_addr), .m1_ar_len(8'd0), .m1_ar_size(3'd3), .m1_ar_burst(2'd1),
    .m1_ar_lock(1'b0), .m1_ar_cache(4'd0), .m1_ar_prot(3'd0), .m1_ar_qos(m1_ar_qos),
    .m1_ar_region(4'd0), .m1_ar_user(1'b0),
    .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready), .m1_r_id(m1_r_id),
    .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp), .m1_r_last(m1_r_last), .m1_r_user(m1_r_user),
    .m1_aw_ready(m1_aw_ready), .m1_w_ready(m1_w_ready), .m1_b_valid(m1_b_valid),
    .m1_b_id(m1_b_id), .m1_b_resp(m1_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id),
    .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
    .s_ar_burst(s_ar_burst), .s_ar_lock(s_ar_lock), .s_ar_cache(s_ar_cache),
    .s_ar_prot(s_ar_prot), .s_ar_qos(s_ar_qos), .s_ar_region(s_ar_region),
    .s_ar_user(s_ar_user),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
    .s_r_resp(2'b00), .s_r_last(s_r_last), .s_r_user(1'b0),
    .s_aw_valid(s_aw_valid), .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr),
    .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
    .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_w_last(s_w_last), .s_b_ready(s_b_ready)
  );

  typedef struct { logic [4:0] id; logic [31:0] addr; } ar_exp_t;
  typedef struct { logic [3:0] id; logic [63:0] data; logic last; } r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r0_q[$];
  r_exp_t  r1_q[$];

  int checks = 0;
  int errors = 0;
  int ar_hs_cnt = 0;
  int out_m[2] = '{0, 0};
  bit gap_check = 0;
  bit have_last_ar = 0;
  longint last_ar_t = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ar(input logic [4:0] id, input logic [31:0] addr);
    ar_exp_t e;
    e.id = id;
    e.addr = addr;
    ar_q.push_back(e);
  endtask

  // Scoreboard monitor: compares every handshake the DUT presents.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_ar_valid && s_ar_ready) begin
        ar_hs_cnt++;
        if (ar_q.size() == 0) begin
          check("ar_unexpected", {59'd0, s_ar_id}, 64'hDEAD);
        end else begin
          ar_exp_t e;
          e = ar_q.pop_front();
          check("s_ar_id", {59'd0, s_ar_id}, {59'd0, e.id});
          check("s_ar_addr", {32'd0, s_ar_addr}, {32'd0, e.addr});
          check("granted_ar_ready", {62'd0, m1_ar_ready, m0_ar_ready},
                e.id[4] ? 64'd2 : 64'd1);
        end
        if (gap_check && have_last_ar)
          check("ar_gap_ns", 64'($time - last_ar_t), 64'd20);
        have_last_ar = 1;
        last_ar_t = $time;
        out_m[s_ar_id[4]]++;
      end
      check("r_valid_onehot", {63'd0, m0_r_valid && m1_r_valid}, 64'd0);
      if (m0_r_valid && m0_r_ready) begin
        if (r0_q.size() == 0) check("r0_unexpected", {60'd0, m0_r_id}, 64'hDEAD);
        else begin
          r_exp_t e;
          e = r0_q.pop_front();
          check("m0_r_id", {60'd0, m0_r_id}, {60'd0, e.id});
          check("m0_r_data", m0_r_data, e.data);
          check("m0_r_last", {63'd0, m0_r_last}, {63'd0, e.last});
        end
      end
      if (m1_r_valid && m1_r_ready) begin
        if (r1_q.size() == 0) check("r1_unexpected", {60'd0, m1_r_id}, 64'hDEAD);
        else begin
          r_exp_t e;
          e = r1_q.pop_front();
          check("m1_r_id", {60'd0, m1_r_id}, {60'd0, e.id});
          check("m1_r_data", m1_r_data, e.data);
          check("m1_r_last", {63'd0, m1_r_last}, {63'd0, e.last});
        end
      end
      if (s_r_valid && s_r_ready && s_r_last) begin
        check("r_last_has_outstanding", {63'd0, out_m[s_r_id[4]] > 0}, 64'd1);
        if (out_m[s_r_id[4]] > 0) out_m[s_r_id[4]]--;
      end
    end
  end

  // Master AR driver: hold valid until the handshake, bounded. Call at posedge+1.
  task automatic ar_req(input int m, input logic [3:0] id, input logic [31:0] addr,
                        input logic [3:0] qos);
    bit done = 0;
    int n = 0;
    if (m == 0) begin m0_ar_valid = 1; m0_ar_id = id; m0_ar_addr = addr; m0_ar_qos = qos; end
    else        begin m1_ar_valid = 1; m1_ar_id = id; m1_ar_addr = addr; m1_ar_qos = qos; end
    while (!done && n < 60) begin
      @(negedge clk);
      if ((m == 0) ? m0_ar_ready : m1_ar_ready) done = 1;
      @(posedge clk);
      #1;
      n++;
    end
    if (m == 0) m0_ar_valid = 0; else m1_ar_valid = 0;
    if (!done) check("ar_req_timeout", 64'(m), 64'hFF);
  endtask

  // Slave R driver: present one beat until accepted, bounded. Call at posedge+1.
  task automatic r_beat(input logic [4:0] id, input logic [63:0] data, input logic last);
    r_exp_t e;
    bit done = 0;
    int n = 0;
    e.id = id[3:0];
    e.data = data;
    e.last = last;
    if (id[4]) r1_q.push_back(e); else r0_q.push_back(e);
    s_r_valid = 1; s_r_id = id; s_r_data = data; s_r_last = last;
    while (!done && n < 40) begin
      @(negedge clk);
      if (s_r_ready) done = 1;
      @(posedge clk);
      #1;
      n++;
    end
    s_r_valid = 0; s_r_last = 0;
    if (!done) check("r_beat_timeout", {59'd0, id}, 64'hFF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reset state
    @(negedge clk);
    check("rst_ar_ready", {62'd0, m1_ar_ready, m0_ar_ready}, 64'd0);
    check("rst_s_ar_valid", {63'd0, s_ar_valid}, 64'd0);
    check("rst_r_valid", {62'd0, m1_r_valid, m0_r_valid}, 64'd0);
    check("rst_cnt0", 64'(dut.cnt_q[0]), 64'd0);
    check("rst_cnt1", 64'(dut.cnt_q[1]), 64'd0);
    check("rst_s_b_ready", {63'd0, s_b_ready}, 64'd1);
    check("rst_write_tieoff", {63'd0, |{m0_aw_ready, m0_w_ready, m0_b_valid, m0_b_id, m0_b_resp,
          m1_aw_ready, m1_w_ready, m1_b_valid, m1_b_id, m1_b_resp, s_aw_valid, s_aw_id,
          s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_w_valid, s_w_data, s_w_strb, s_w_last}},
          64'd0);
    check("rst_outputs_zero", {63'd0, |{s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst,
          s_ar_lock, s_ar_cache, s_ar_prot, s_ar_qos, s_ar_region, s_ar_user, m0_r_id,
          m0_r_data, m0_r_resp, m0_r_last, m0_r_user, m1_r_id, m1_r_data, m1_r_resp,
          m1_r_last, m1_r_user}}, 64'd0);

    // Fairness: both continuously requesting, one AR every 2 cycles
    @(posedge clk); #1;
    push_ar(5'h03, 32'hA000); push_ar(5'h15, 32'hB000);
    push_ar(5'h03, 32'hA100); push_ar(5'h15, 32'hB100);
    gap_check = 1; have_last_ar = 0;
    fork
      begin ar_req(0, 4'h3, 32'hA000, 4'h0); ar_req(0, 4'h3, 32'hA100, 4'h0); end
      begin ar_req(1, 4'h5, 32'hB000, 4'h0); ar_req(1, 4'h5, 32'hB100, 4'h0); end
    join
    gap_check = 0;
    @(negedge clk);
    check("fair_cnt0", 64'(dut.cnt_q[0]), 64'd2);
    check("fair_cnt1", 64'(dut.cnt_q[1]), 64'd2);

    // Interleaved R with m1 backpressure
    @(posedge clk); #1;
    begin
      r_exp_t e;
      e.id = 4'h2; e.data = 64'h1111; e.last = 1;
      r1_q.push_back(e);
    end
    m1_r_ready = 0;
    s_r_valid = 1; s_r_id = 5'h12; s_r_data = 64'h1111; s_r_last = 1;
    repeat (2) begin
      @(negedge clk);
      check("bp_s_r_ready", {63'd0, s_r_ready}, 64'd0);
      check("bp_m1_r_valid", {63'd0, m1_r_valid}, 64'd1);
      check("bp_m0_r_valid", {63'd0, m0_r_valid}, 64'd0);
      check("bp_m1_r_id", {60'd0, m1_r_id}, 64'd2);
    end
    @(posedge clk); #1;
    m1_r_ready = 1;
    @(posedge clk); #1;
    s_r_valid = 0; s_r_last = 0;
    s_r_valid = 1; s_r_id = 5'h02; s_r_data = 64'h2222; s_r_last = 0;
    @(negedge clk);
    check("il_m0_r_valid", {63'd0, m0_r_valid}, 64'd1);
    check("il_m1_r_valid", {63'd0, m1_r_valid}, 64'd0);
    check("il_m0_r_id", {60'd0, m0_r_id}, 64'd2);
    begin
      r_exp_t e;
      e.id = 4'h2; e.data = 64'h2222; e.last = 0;
      r0_q.push_back(e);
    end
    @(posedge clk); #1;
    s_r_valid = 0;
    @(negedge clk);
    check("mid_burst_cnt0", 64'(dut.cnt_q[0]), 64'd2);
    @(posedge clk); #1;
    r_beat(5'h02, 64'h3333, 1);
    r_beat(5'h15, 64'h4444, 1);
    r_beat(5'h03, 64'h5555, 1);
    @(negedge clk);
    check("drain_cnt0", 64'(dut.cnt_q[0]), 64'd0);
    check("drain_cnt1", 64'(dut.cnt_q[1]), 64'd0);

    // Outstanding limit: third AR from m0 stalls until one r_last
    @(posedge clk); #1;
    base = ar_hs_cnt;
    push_ar(5'h01, 32'hC000); push_ar(5'h01, 32'hC100); push_ar(5'h01, 32'hC200);
    fork
      begin
        ar_req(0, 4'h1, 32'hC000, 4'h0);
        ar_req(0, 4'h1, 32'hC100, 4'h0);
        ar_req(0, 4'h1, 32'hC200, 4'h0);
      end
      begin
        n = 0;
        while (ar_hs_cnt < base + 2 && n < 40) begin @(negedge clk); n++; end
        check("limit_two_issued", 64'(ar_hs_cnt - base), 64'd2);
        repeat (3) begin
          @(negedge clk);
          check("limit_stall_s_ar_valid", {63'd0, s_ar_valid}, 64'd0);
          check("limit_stall_m0_ready", {63'd0, m0_ar_ready}, 64'd0);
        end
        check("limit_cnt0", 64'(dut.cnt_q[0]), 64'd2);
        @(posedge clk); #1;
        begin
          r_exp_t e;
          e.id = 4'h1; e.data = 64'h6666; e.last = 1;
          r0_q.push_back(e);
        end
        s_r_valid = 1; s_r_id = 5'h01; s_r_data = 64'h6666; s_r_last = 1;
        @(posedge clk); #1;
        s_r_valid = 0; s_r_last = 0;
        @(negedge clk);
        check("limit_release_idle", {63'd0, s_ar_valid}, 64'd0);
        check("limit_release_cnt0", 64'(dut.cnt_q[0]), 64'd1);
        @(negedge clk);
        check("limit_reissue_valid", {63'd0, s_ar_valid}, 64'd1);
        check("limit_reissue_id", {59'd0, s_ar_id}, 64'h01);
      end
    join
    @(posedge clk); #1;
    r_beat(5'h01, 64'h7777, 1);
    @(negedge clk);
    check("pre_same_cnt0", 64'(dut.cnt_q[0]), 64'd1);

    // Same-cycle AR handshake and r_last for m0 at cnt = 1
    @(posedge clk); #1;
    s_ar_ready = 0;
    push_ar(5'h07, 32'hD000);
    fork
      ar_req(0, 4'h7, 32'hD000, 4'h0);
      begin
        @(posedge clk);
        @(negedge clk);
        check("same_issue_valid", {63'd0, s_ar_valid}, 64'd1);
        check("same_stall_ready", {63'd0, m0_ar_ready}, 64'd0);
        @(posedge clk); #1;
        begin
          r_exp_t e;
          e.id = 4'h0; e.data = 64'h8888; e.last = 1;
          r0_q.push_back(e);
        end
        s_ar_ready = 1;
        s_r_valid = 1; s_r_id = 5'h00; s_r_data = 64'h8888; s_r_last = 1;
        @(posedge clk); #1;
        s_r_valid = 0; s_r_last = 0;
        @(negedge clk);
        check("same_cycle_cnt0", 64'(dut.cnt_q[0]), 64'd1);
      end
    join
    @(posedge clk); #1;
    r_beat(5'h07, 64'h9999, 1);

    // QoS scenario A: ptr = 1, m0 qos 7, m1 qos 2
`ifdef AXI_RD_ARB_QOS_EN
    push_ar(5'h0A, 32'hE000); push_ar(5'h1B, 32'hE100);
`else
    push_ar(5'h1B, 32'hE100); push_ar(5'h0A, 32'hE000);
`endif
    fork
      ar_req(0, 4'hA, 32'hE000, 4'h7);
      ar_req(1, 4'hB, 32'hE100, 4'h2);
    join
    r_beat(5'h0A, 64'hA0, 1);
    r_beat(5'h1B, 64'hB0, 1);

    // QoS scenario B: m0 qos 2, m1 qos 7 -> m1 first
    push_ar(5'h1D, 32'hF100); push_ar(5'h0C, 32'hF000);
    fork
      ar_req(0, 4'hC, 32'hF000, 4'h2);
      ar_req(1, 4'hD, 32'hF100, 4'h7);
    join
    r_beat(5'h0C, 64'hC0, 1);
    r_beat(5'h1D, 64'hD0, 1);

    // Solo m1 grant sets ptr = 0, then equal QoS -> m0 first
    push_ar(5'h1E, 32'h1E00);
    ar_req(1, 4'hE, 32'h1E00, 4'h3);
    r_beat(5'h1E, 64'hE0, 1);
    push_ar(5'h06, 32'h0600); push_ar(5'h19, 32'h1900);
    fork
      ar_req(0, 4'h6, 32'h0600, 4'h3);
      ar_req(1, 4'h9, 32'h1900, 4'h3);
    join
    r_beat(5'h06, 64'h60, 1);
    r_beat(5'h19, 64'h90, 1);

    // Final drain
    n = 0;
    while ((ar_q.size() + r0_q.size() + r1_q.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("final_ar_q_empty", 64'(ar_q.size()), 64'd0);
    check("final_r0_q_empty", 64'(r0_q.size()), 64'd0);
    check("final_r1_q_empty", 64'(r1_q.size()), 64'd0);
    check("final_cnt0", 64'(dut.cnt_q[0]), 64'd0);
    check("final_cnt1", 64'(dut.cnt_q[1]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
